// File: rtl/register_rd_buffer_pkg.sv
// -----------------------------------------------------------------------------
// register_rd_buffer_pkg
// Shared types for the two-entry read-side elastic buffer.
//   state_t : occupancy state of the buffer (EMPTY / ONE / FULL)
// -----------------------------------------------------------------------------
package register_rd_buffer_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_t;

endpackage : register_rd_buffer_pkg

// File: rtl/register_rd_buffer_buf_slot.sv
// -----------------------------------------------------------------------------
// buf_slot
// One storage slot of the elastic buffer: a DATA_WIDTH register with a load
// enable and a synchronous active-low clear.
// Ports:
//   clk     : rising-edge clock
//   arstn   : synchronous active-low clear (sampled on posedge clk)
//   load_en : capture d on the next rising edge
//   d       : data to capture
//   q       : stored word
// -----------------------------------------------------------------------------
module buf_slot #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  load_en,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] data_r;

    // Slot storage: clear on reset, otherwise load when enabled.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            data_r <= {DATA_WIDTH{1'b0}};
        end else if (load_en) begin
            data_r <= d;
        end else begin
            data_r <= data_r;
        end
    end

    assign q = data_r;

endmodule : buf_slot

// File: rtl/register_rd_buffer.sv
// -----------------------------------------------------------------------------
// register_rd_buffer
// Two-entry elastic buffer between a producer (write side) and a consumer
// (read side). Strict FIFO order; a push into a full buffer is dropped and
// flagged on o_drop for one cycle.
//
// Optional feature macro: REGISTER_RD_BUFFER_BYPASS_EN
//   When defined, a push into an EMPTY buffer is presented on o_read_data /
//   o_valid in the same cycle; if it is also read that cycle it is consumed
//   and the buffer stays EMPTY. o_ready stays purely registered.
//
// Ports:
//   clk          : rising-edge clock
//   arstn        : synchronous active-low reset
//   i_write_en   : producer push request
//   i_write_data : push data
//   o_ready      : buffer can accept a push this cycle
//   i_read_en    : consumer pop request
//   o_valid      : o_read_data holds a valid entry
//   o_read_data  : head entry
//   o_drop       : one-cycle pulse after a push was rejected (buffer full)
// -----------------------------------------------------------------------------
module register_rd_buffer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  i_write_en,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    output logic                  o_ready,
    input  logic                  i_read_en,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_read_data,
    output logic                  o_drop
);

    import register_rd_buffer_pkg::*;

    state_t                state_r;
    state_t                state_next_s;
    logic                  rst_done_r;
    logic                  drop_r;

    logic                  ready_s;
    logic                  valid_s;
    logic                  bypass_s;
    logic                  push_s;
    logic                  pop_s;

    logic                  head_load_s;
    logic                  tail_load_s;
    logic                  head_sel_tail_s;
    logic [DATA_WIDTH-1:0] head_d_s;
    logic [DATA_WIDTH-1:0] head_q_s;
    logic [DATA_WIDTH-1:0] tail_q_s;

    // Handshake decode. rst_done_r keeps o_ready low while reset is held;
    // both terms are registers, so there is no path from i_read_en to o_ready.
    always_comb begin
        ready_s  = rst_done_r & (state_r != FULL);
`ifdef REGISTER_RD_BUFFER_BYPASS_EN
        bypass_s = rst_done_r & (state_r == EMPTY) & i_write_en;
`else
        bypass_s = 1'b0;
`endif
        valid_s  = (state_r != EMPTY) | bypass_s;
        push_s   = i_write_en & ready_s;
        pop_s    = i_read_en & valid_s;
    end

    // Next-state and slot-load decode.
    always_comb begin
        state_next_s    = state_r;
        head_load_s     = 1'b0;
        tail_load_s     = 1'b0;
        head_sel_tail_s = 1'b0;
        case (state_r)
            EMPTY: begin
                if (push_s) begin
                    // Head is written even when a bypassed word is consumed;
                    // o_read_data is don't-care in EMPTY.
                    head_load_s = 1'b1;
                    if (pop_s) begin
                        state_next_s = EMPTY;
                    end else begin
                        state_next_s = ONE;
                    end
                end else begin
                    state_next_s = EMPTY;
                end
            end
            ONE: begin
                if (push_s && pop_s) begin
                    head_load_s  = 1'b1;
                    state_next_s = ONE;
                end else if (push_s) begin
                    tail_load_s  = 1'b1;
                    state_next_s = FULL;
                end else if (pop_s) begin
                    state_next_s = EMPTY;
                end else begin
                    state_next_s = ONE;
                end
            end
            FULL: begin
                if (pop_s) begin
                    head_load_s     = 1'b1;
                    head_sel_tail_s = 1'b1;
                    state_next_s    = ONE;
                end else begin
                    state_next_s = FULL;
                end
            end
            default: begin
                state_next_s = EMPTY;
            end
        endcase
    end

    // Head is refilled either from the input or from the tail slot.
    always_comb begin
        if (head_sel_tail_s) begin
            head_d_s = tail_q_s;
        end else begin
            head_d_s = i_write_data;
        end
    end

    // State, reset-done flag and drop pulse registers.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            state_r    <= EMPTY;
            rst_done_r <= 1'b0;
            drop_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            rst_done_r <= 1'b1;
            drop_r     <= i_write_en & ~ready_s;
        end
    end

    buf_slot #(.DATA_WIDTH(DATA_WIDTH)) u_head (
        .clk     (clk),
        .arstn   (arstn),
        .load_en (head_load_s),
        .d       (head_d_s),
        .q       (head_q_s)
    );

    buf_slot #(.DATA_WIDTH(DATA_WIDTH)) u_tail (
        .clk     (clk),
        .arstn   (arstn),
        .load_en (tail_load_s),
        .d       (i_write_data),
        .q       (tail_q_s)
    );

    assign o_ready     = ready_s;
    assign o_valid     = valid_s;
    assign o_read_data = bypass_s ? i_write_data : head_q_s;
    assign o_drop      = drop_r;

endmodule : register_rd_buffer

// File: tb/tb_register_rd_buffer.sv
// Directed bench for register_rd_buffer.
module tb_register_rd_buffer;

    localparam int DW = 32;

    logic          clk;
    logic          arstn;
    logic          i_write_en;
    logic [DW-1:0] i_write_data;
    logic          o_ready;
    logic          i_read_en;
    logic          o_valid;
    logic [DW-1:0] o_read_data;
    logic          o_drop;

    int checks = 0;
    int errors = 0;

    register_rd_buffer #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .arstn        (arstn),
        .i_write_en   (i_write_en),
        .i_write_data (i_write_data),
        .o_ready      (o_ready),
        .i_read_en    (i_read_en),
        .o_valid      (o_valid),
        .o_read_data  (o_read_data),
        .o_drop       (o_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        arstn        = 1'b0;
        i_write_en   = 1'b1;
        i_write_data = 32'h0000_0011;
        i_read_en    = 1'b0;

        // Reset held for two edges with a push request pending.
        tick();
        tick();
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_data",  o_read_data, 32'd0);
        check("rst_drop",  {31'd0, o_drop}, 32'd0);
        check("rst_ready", {31'd0, o_ready}, 32'd0);
        arstn      = 1'b1;
        i_write_en = 1'b0;
        tick();
        check("post_rst_ready", {31'd0, o_ready}, 32'd1);
        check("post_rst_valid", {31'd0, o_valid}, 32'd0);
        check("post_rst_drop",  {31'd0, o_drop}, 32'd0);

        // Fill to FULL.
        i_write_en   = 1'b1;
        i_write_data = 32'hA5A5_0001;
        tick();
        check("fill1_valid", {31'd0, o_valid}, 32'd1);
        check("fill1_data",  o_read_data, 32'hA5A5_0001);
        check("fill1_ready", {31'd0, o_ready}, 32'd1);
        i_write_data = 32'hA5A5_0002;
        tick();
        check("full_ready", {31'd0, o_ready}, 32'd0);
        check("full_data",  o_read_data, 32'hA5A5_0001);

        // Overflow attempt.
        i_write_data = 32'hDEAD_BEEF;
        tick();
        check("ovf_drop",  {31'd0, o_drop}, 32'd1);
        check("ovf_data",  o_read_data, 32'hA5A5_0001);
        check("ovf_ready", {31'd0, o_ready}, 32'd0);
        i_write_en = 1'b0;
        tick();
        check("ovf_drop_clear", {31'd0, o_drop}, 32'd0);

        // Drain.
        i_read_en = 1'b1;
        tick();
        check("drain1_data",  o_read_data, 32'hA5A5_0002);
        check("drain1_valid", {31'd0, o_valid}, 32'd1);
        check("drain1_ready", {31'd0, o_ready}, 32'd1);
        tick();
        check("drain2_valid", {31'd0, o_valid}, 32'd0);
        i_read_en = 1'b0;

        // Streaming: push every cycle, read from the second cycle on.
        for (int i = 0; i < 100; i++) begin
            i_write_en   = 1'b1;
            i_write_data = 32'h0000_0100 + i;
            i_read_en    = (i >= 1);
            #1;
            check("stream_ready", {31'd0, o_ready}, 32'd1);
            if (i >= 1) begin
                check("stream_valid", {31'd0, o_valid}, 32'd1);
                check("stream_data",  o_read_data, 32'h0000_0100 + i - 1);
            end
            tick();
            check("stream_drop", {31'd0, o_drop}, 32'd0);
        end
        i_write_en = 1'b0;
        i_read_en  = 1'b1;
        #1;
        check("stream_last", o_read_data, 32'h0000_0163);
        tick();
        i_read_en = 1'b0;
        check("stream_empty", {31'd0, o_valid}, 32'd0);

        // Reads against an empty buffer.
        i_read_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("empty_rd_valid", {31'd0, o_valid}, 32'd0);
            check("empty_rd_ready", {31'd0, o_ready}, 32'd1);
        end
        i_read_en    = 1'b0;
        i_write_en   = 1'b1;
        i_write_data = 32'h0000_1234;
        tick();
        i_write_en = 1'b0;
        check("after_empty_valid", {31'd0, o_valid}, 32'd1);
        check("after_empty_data",  o_read_data, 32'h0000_1234);
        i_read_en = 1'b1;
        tick();
        i_read_en = 1'b0;
        check("after_empty_pop", {31'd0, o_valid}, 32'd0);

        // Reset while FULL.
        i_write_en   = 1'b1;
        i_write_data = 32'h0000_0001;
        tick();
        i_write_data = 32'h0000_0002;
        tick();
        i_write_en = 1'b0;
        check("midrst_full", {31'd0, o_ready}, 32'd0);
        arstn = 1'b0;
        tick();
        check("midrst_valid", {31'd0, o_valid}, 32'd0);
        check("midrst_drop",  {31'd0, o_drop}, 32'd0);
        arstn = 1'b1;
        tick();
        check("midrst_ready",  {31'd0, o_ready}, 32'd1);
        check("midrst_valid2", {31'd0, o_valid}, 32'd0);

        // Push with simultaneous read while EMPTY.
        i_write_en   = 1'b1;
        i_write_data = 32'h0000_0055;
        i_read_en    = 1'b1;
        #1;
`ifdef REGISTER_RD_BUFFER_BYPASS_EN
        check("byp_valid", {31'd0, o_valid}, 32'd1);
        check("byp_data",  o_read_data, 32'h0000_0055);
        tick();
        i_write_en = 1'b0;
        i_read_en  = 1'b0;
        #1;
        check("byp_stay_empty", {31'd0, o_valid}, 32'd0);
`else
        check("nobyp_valid", {31'd0, o_valid}, 32'd0);
        tick();
        i_write_en = 1'b0;
        i_read_en  = 1'b0;
        #1;
        check("nobyp_one_valid", {31'd0, o_valid}, 32'd1);
        check("nobyp_one_data",  o_read_data, 32'h0000_0055);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_register_rd_buffer
